// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with frame locking that shares one 8N1 uart_tx among N
// byte-stream requesters, sequencing each byte through the start/idle handshake.
module uart_tx_arbiter #(
    parameter int N             = 4,
    parameter int ACK_TIMEOUT   = 16,
    parameter int STALL_TIMEOUT = 104160
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_idle,
    output logic           frame_abort,
    output logic           ack_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
    localparam logic [AW-1:0] ACK_LIMIT   = AW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_TIMEOUT - 1);
    localparam logic [IW:0]   N_WIDE      = (IW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          locked_q, locked_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          last_q, last_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    logic [N-1:0]  grant_d, ready_d;
    logic [7:0]    tx_data_d;
    logic          tx_start_d, abort_d, ack_err_d;

    logic          found;
    logic [IW-1:0] winner;
    logic [IW:0]   rr_sum;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] sel;
    logic          sel_valid;
    logic [7:0]    sel_byte;
    logic [IW-1:0] owner_next;
    logic          end_of_byte;

    // Round-robin search: first valid requester at or after ptr, wrapping mod N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_sum = '0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, ptr_q} + (IW + 1)'(k);
            if (rr_sum >= N_WIDE) begin
                rr_sum = rr_sum - N_WIDE;
            end
            rr_idx = rr_sum[IW-1:0];
            if (!found && req_valid[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    // While locked only the owner is eligible; everyone else is ignored.
    always_comb begin
        sel        = locked_q ? owner_q : winner;
        sel_valid  = locked_q ? req_valid[owner_q] : found;
        sel_byte   = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
        owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
    end

    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold it.
    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        ack_cnt_d   = ack_cnt_q;
        stall_cnt_d = stall_cnt_q;
        grant_d     = grant;
        tx_data_d   = tx_data;
        tx_start_d  = 1'b0;
        ready_d     = '0;
        abort_d     = 1'b0;
        ack_err_d   = 1'b0;
        end_of_byte = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_valid && tx_idle) begin
                    owner_d      = sel;
                    locked_d     = 1'b1;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    tx_data_d    = sel_byte;
                    last_d       = req_last[sel];
                    tx_start_d   = 1'b1;
                    ready_d[sel] = 1'b1;
                    ack_cnt_d    = '0;
                    state_d      = WAIT_ACK;
                end else if (locked_q && !req_valid[owner_q]) begin
                    if (stall_cnt_q == STALL_LIMIT) begin
                        locked_d    = 1'b0;
                        grant_d     = '0;
                        abort_d     = 1'b1;
                        ptr_d       = owner_next;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SW'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (!tx_idle) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LIMIT) begin
                    // The transmitter never acknowledged; count the byte as sent.
                    ack_err_d   = 1'b1;
                    end_of_byte = 1'b1;
                    state_d     = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_idle) begin
                    end_of_byte = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_of_byte) begin
            stall_cnt_d = '0;
            if (last_q) begin
                locked_d = 1'b0;
                grant_d  = '0;
                ptr_d    = owner_next;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            locked_q    <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            last_q      <= 1'b0;
            ack_cnt_q   <= '0;
            stall_cnt_q <= '0;
            grant       <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            frame_abort <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            ack_cnt_q   <= ack_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            grant       <= grant_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            req_ready   <= ready_d;
            frame_abort <= abort_d;
            ack_err     <= ack_err_d;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (8N1, 9600 baud at 50 MHz, 5208 clocks per bit) between N byte-stream requesters. Arbitration is round-robin with frame locking: once a requester wins, it keeps the transmitter until it sends a byte marked last, or until its stall timeout expires. The block sits between on-chip data sources (loopback echo, status reporter, debug dump, etc.) and the uart_tx instance. It sequences each byte through the transmitter's start/idle handshake.

Parameters:
N, 4, number of requesters (2..8)
ACK_TIMEOUT, 16, clocks allowed for tx_idle to fall after tx_start
STALL_TIMEOUT, 104160, clocks a locked requester may hold req_valid low mid-frame (2 byte times)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
req_valid  in  N  per-requester byte available; held until req_ready
req_data  in  8*N  byte for requester i in bits [8i+7:8i]
req_last  in  N  byte is the final byte of its frame
req_ready  out  N  one-cycle pulse: byte from requester i accepted
grant  out  N  one-hot, owner of the transmitter; zero when unlocked
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to uart_tx, stable from tx_start until tx_idle returns high
tx_idle  in  1  uart_tx idle/empty flag (high = line idle, ready)
frame_abort  out  1  one-cycle pulse: locked frame released by stall timeout
ack_err  out  1  one-cycle pulse: tx_idle did not fall within ACK_TIMEOUT

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0; state IDLE; lock cleared; rr pointer = 0; counters = 0. Reset mid-byte drops the byte with no ack_err or abort.
- States: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE, unlocked:
  - If tx_idle=1 and any req_valid is set, the winner is the first set bit searching i = ptr, ptr+1, ... mod N.
  - On that edge: tx_data <= winner byte; grant <= onehot(winner); lock set. Next cycle tx_start=1 and req_ready[winner]=1, each for exactly one cycle. Go to WAIT_ACK.
  - Latency: valid sampled at edge k; start and ready pulse in cycle k+1.
- IDLE, locked to owner o:
  - Only req_valid[o] is considered; other requesters are ignored.
  - If req_valid[o]=1 and tx_idle=1, capture the byte and issue it exactly as above, with the same latency.
  - While req_valid[o]=0, the stall counter increments. When it reaches STALL_TIMEOUT: clear lock, grant <= 0, pulse frame_abort, set ptr = o+1 mod N.
- WAIT_ACK:
  - Count cycles. When tx_idle=0 is seen, go to WAIT_DONE.
  - If the count reaches ACK_TIMEOUT: pulse ack_err, treat the byte as sent, and apply the end-of-byte rule.
- WAIT_DONE: when tx_idle=1, apply the end-of-byte rule and go to IDLE.
- End-of-byte rule:
  - If the captured last flag is 1: clear lock, grant <= 0, ptr = owner+1 mod N.
  - Otherwise keep the lock and clear the stall counter.
- The last flag is captured with the byte at acceptance; later changes to req_last are ignored.
- Accepted bytes are never dropped except by reset. Non-owner req_valid may stay high indefinitely without being accepted.
- tx_idle=0 while in IDLE blocks all issue, including abort-free waiting; the stall counter still runs only while the owner has no valid.
- At most one req_ready bit is high in any cycle. grant is always one-hot or zero.

Test Plan:
1. Single byte: requester 0 sends 8'haa with last=1 -> tx_start one cycle after valid; req_ready[0] pulses once; tx_data=8'haa; grant returns 0 after tx_idle rises; the serial line carries 0xAA.
2. Round-robin: all 4 requesters send single-byte frames 8'h10..8'h13 continuously -> transmit order 0,1,2,3,0,1; no requester is served twice before another waiting one.
3. Frame lock: requester 2 sends a 3-byte frame (8'haf, 8'h0a, 8'h0e, last on 8'h0e) while requester 1 holds valid -> all 3 bytes from requester 2 go first, then requester 1.
4. Stall abort: requester 3 sends 1 byte with last=0, then drops valid (STALL_TIMEOUT=100 for the test) -> frame_abort pulses 100 cycles after the byte completes; grant=0; requester 0's pending byte is served next.
5. Ack error: the transmitter model holds tx_idle=1 after tx_start -> ack_err pulses ACK_TIMEOUT cycles after tx_start; the FSM returns to IDLE; the next byte is issued normally.
6. Reset mid-frame: assert sys_rst_n=0 during WAIT_DONE of byte 2 of a locked frame -> all outputs 0 at once; after release, a fresh requester 0 byte is served with ptr=0.
